acc_stream_tx: RTL
==================

# acc_stream_tx

Transmit-side streamer for the accumulator's valid/ready input. Software preloads 32-bit words into a local FIFO through a simple write port, then issues `Start` with a group count. The block emits exactly `NumGroups × GroupSize` words, flags the last word of each group, and pulses `Done` after the final transfer. It sits between the Nios II register slave and the accumulator's data input.

## Interface
Parameters:
- `DataWidth`, 32, word width.
- `GroupSize`, 4, words per accumulation group (≥2).
- `GroupCountWidth`, 2, width of the in-group element counter; `2^GroupCountWidth ≥ GroupSize`.
- `BufferWidth`, 3, FIFO address width; depth = 2^BufferWidth.
- `TileCountWidth`, 8, width of `NumGroups` and of the group counter.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `sclr` in 1: synchronous, active-high reset; acts only on a rising edge; takes effect regardless of `clk_en`.
- `clk_en` in 1: global enable; when low, all state holds.
- `Start` in 1: launch pulse; sampled only in IDLE.
- `NumGroups` in TileCountWidth: number of groups to send; latched on an accepted `Start`.
- `WrEn` in 1: push `WrData` into the FIFO.
- `WrData` in DataWidth: word to push.
- `WrFull` out 1: FIFO full.
- `DataOutValid` out 1: stream valid.
- `DataOutRdy` in 1: stream ready from the accumulator.
- `DataOut` out DataWidth: FIFO head.
- `DataOutLast` out 1: current word is the last of its group.
- `Busy` out 1: state is SEND.
- `Done` out 1: one-cycle completion pulse.
- `UnderrunCount` out 16: starvation counter (see Configuration).

## Operation
- **FIFO.** Circular buffer with read/write pointers that wrap modulo depth, and an occupancy count 0..depth.
  - A push occurs when `WrEn & ~WrFull & clk_en`.
  - A write while full is dropped silently.
  - Writes are accepted in every state, so the FIFO can be preloaded before `Start`.
- **Transfer.** A transfer occurs when `DataOutValid & DataOutRdy & clk_en`; it pops the FIFO.
  - Push and pop in the same cycle leave the count unchanged. This is legal at any non-full, non-empty occupancy.
  - When full, the push is dropped and the pop proceeds.
- **State machine.**
  - IDLE: on `Start & clk_en`, latch `NumGroups` and clear the element and group counters.
    - If `NumGroups == 0`, go to DONE.
    - Otherwise go to SEND.
  - SEND: `DataOutValid = ~Empty`. On each transfer, the element counter increments and wraps to 0 after `GroupSize-1`. When the wrap transfer completes, the group counter increments. If it then equals the latched count, go to DONE.
  - DONE: `Done = 1` for one enabled cycle, then return to IDLE.
- **Outputs by state.**
  - `DataOutLast = DataOutValid & (ElemCnt == GroupSize-1)`.
  - `DataOutValid` is 0 outside SEND.
  - `DataOut` always shows the FIFO head, and is a don't-care when not valid.
- **Handshake rules.** Once `DataOutValid` is high, it and `DataOut` stay stable until the transfer occurs. Valid never drops without a transfer, and `Start` during SEND or DONE is ignored.
- **Leftovers.** Words remaining after DONE stay in the FIFO for the next `Start`.
- **Reset.** `sclr` empties the FIFO, zeroes the pointers and counters, and sets state to IDLE. After reset:
  - `DataOutValid`, `DataOutLast`, `Busy`, `Done` and `WrFull` are 0.
  - `UnderrunCount` is 0.
  - `DataOut` is 0.
  - Mid-stream reset abandons the tile with no `Done` pulse.

## Timing
- Push to visibility: a word pushed at edge t can transfer at edge t+1 at the earliest. The count is registered; there is no fall-through.
- `Start` accepted at edge t: `Busy` and `DataOutValid` are high from t+1 if the FIFO is non-empty.
- Throughput: one word per cycle with `DataOutRdy` held high and the FIFO non-empty.
- `Done` is high in the cycle after the final transfer edge. `Busy` is low in that same cycle.
- `WrFull` updates in the cycle after the push that fills the FIFO.

## Configuration
- `ACC_STREAM_TX_UNDERRUN_CNT_EN` defined:
  - `UnderrunCount` increments every enabled cycle in SEND with the FIFO empty.
  - It saturates at 0xFFFF.
  - It is cleared by `sclr` and by an accepted `Start`.
- Not defined: `UnderrunCount` is tied to 0, and no counter logic is synthesised.

## Test plan
- **Preloaded single tile.** Preload 8 words 1..8, `NumGroups=2`, `Start`, `DataOutRdy=1`.
  - Expect 8 transfers on consecutive cycles starting the cycle after `Start`.
  - Expect `DataOutLast` on words 4 and 8.
  - Expect `Done` one cycle after the word-8 transfer.
- **Ready back-pressure.** Toggle `DataOutRdy` pseudo-randomly.
  - `DataOut` and `DataOutValid` must hold while `Rdy=0`.
  - Order must be 1..8 with no drops or duplicates.
- **Full FIFO.** Write 9 words with the stream stalled.
  - `WrFull=1` after the 8th write; the 9th is dropped.
  - Then push and transfer in the same cycle at count 7: the count stays at 7.
- **Zero groups and ignored Start.** `NumGroups=0` → `Done` the cycle after `Start`, with no valid asserted.
  - A `Start` during SEND is ignored: the group total is unchanged.
- **Reset and underrun.** Assert `sclr` mid-stream.
  - All outputs return to 0 and the FIFO is empty.
  - With `_EN` defined, SEND with an empty FIFO for 5 cycles gives `UnderrunCount=5`.
  - Without `_EN`, `UnderrunCount` stays 0.

Source files
------------

// File: rtl/acc_stream_tx_if.sv
// acc_stream_tx_if: valid/ready word stream from the streamer to the accumulator input.
interface acc_stream_tx_if #(
  parameter int DataWidth = 32
);
  logic                 DataOutValid;
  logic                 DataOutRdy;
  logic                 DataOutLast;
  logic [DataWidth-1:0] DataOut;
  modport master(output DataOutValid, DataOut, DataOutLast, input DataOutRdy);
  modport slave(input DataOutValid, DataOut, DataOutLast, output DataOutRdy);
endinterface

// File: rtl/acc_stream_tx.sv
// acc_stream_tx: FIFO-backed streamer emitting NumGroups*GroupSize words with group-last flags.
// Optional starvation counter enabled by ACC_STREAM_TX_UNDERRUN_CNT_EN.
module acc_stream_tx #(
  parameter int DataWidth       = 32,
  parameter int GroupSize       = 4,
  parameter int GroupCountWidth = 2,
  parameter int BufferWidth     = 3,
  parameter int TileCountWidth  = 8
) (
  input  logic                      clk,
  input  logic                      sclr,
  input  logic                      clk_en,
  input  logic                      Start,
  input  logic [TileCountWidth-1:0] NumGroups,
  input  logic                      WrEn,
  input  logic [DataWidth-1:0]      WrData,
  output logic                      WrFull,
  output logic                      Busy,
  output logic                      Done,
  output logic [15:0]               UnderrunCount,
  acc_stream_tx_if.master           tx
);
  localparam int Depth = 1 << BufferWidth;
  localparam logic [GroupCountWidth-1:0] LastElem = GroupCountWidth'(GroupSize - 1);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t                    r_state, w_next;
  logic [DataWidth-1:0]      r_mem [Depth];
  logic [BufferWidth-1:0]    r_wptr, r_rptr;
  logic [BufferWidth:0]      r_count;
  logic [GroupCountWidth-1:0] r_elem;
  logic [TileCountWidth-1:0] r_grp, r_num, w_grp_inc;
  logic                      w_full, w_empty, w_push, w_pop, w_wrap, w_launch;
  assign w_full    = r_count == (BufferWidth+1)'(Depth);
  assign w_empty   = r_count == '0;
  assign w_push    = WrEn & ~w_full & clk_en;
  assign w_pop     = tx.DataOutValid & tx.DataOutRdy & clk_en;
  assign w_wrap    = r_elem == LastElem;
  assign w_grp_inc = r_grp + 1'b1;
  assign w_launch  = (r_state == IDLE) & Start;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= WrData;
  always_ff @(posedge clk) begin
    if (sclr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (BufferWidth+1)'(w_push) - (BufferWidth+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (sclr) begin
      r_elem <= '0;
      r_grp  <= '0;
      r_num  <= '0;
    end else if (clk_en) begin
      if (w_launch) begin
        r_num  <= NumGroups;
        r_elem <= '0;
        r_grp  <= '0;
      end else if (w_pop) begin
        r_elem <= w_wrap ? '0 : r_elem + 1'b1;
        if (w_wrap) r_grp <= w_grp_inc;
      end
    end
  end
  always_ff @(posedge clk)
    if (sclr) r_state <= IDLE;
    else if (clk_en) r_state <= w_next;
  always_comb begin
    w_next = r_state == IDLE ? (Start ? (NumGroups == '0 ? DONE : SEND) : IDLE)
           : r_state == SEND ? ((w_pop && w_wrap && w_grp_inc == r_num) ? DONE : SEND)
           : IDLE;
  end
  always_comb begin
    Busy            = r_state == SEND;
    Done            = r_state == DONE;
    WrFull          = w_full;
    tx.DataOutValid = Busy & ~w_empty;
    tx.DataOutLast  = tx.DataOutValid & w_wrap;
    tx.DataOut      = w_empty ? '0 : r_mem[r_rptr];
  end
`ifdef ACC_STREAM_TX_UNDERRUN_CNT_EN
  logic [15:0] r_underrun;
  always_ff @(posedge clk) begin
    if (sclr) r_underrun <= '0;
    else if (clk_en) begin
      if (w_launch) r_underrun <= '0;
      else if (Busy && w_empty && r_underrun != 16'hFFFF) r_underrun <= r_underrun + 1'b1;
    end
  end
  assign UnderrunCount = r_underrun;
`else
  assign UnderrunCount = '0;
`endif
endmodule
